// File: rtl/pipe_skid_buffer_pkg.sv
// Shared definitions for the two-entry skid stage: state encoding and the
// occupancy width, so trace/debug blocks decode count the same way.
package pipe_skid_buffer_pkg;

    // Occupancy is 0, 1 or 2, so two bits suffice.
    localparam int CNT_W = 2;

    // The encoding doubles as the occupancy value: EMPTY=0, BUSY=1, FULL=2.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline stage (main + skid register).
// The stage cuts the combinational path from out_ready to in_ready: every
// handshake output is decoded from the state register alone.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high on that side. A producer holding valid may not withdraw it or change
// data until the transfer happens; this stage holds out_valid/out_data stable
// while out_ready is low, and in_ready never depends on in_valid or out_ready.
module pipe_skid_buffer
    import pipe_skid_buffer_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] count,
    output state_t           dbg_state
);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    logic in_fire;
    logic out_fire;
    logic load_main;
    logic main_from_skid;
    logic load_skid;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // State register; reset forces EMPTY without waiting for a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath load controls; flush overrides everything.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_main = 1'b1;
                        state_d   = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (out_fire) begin
                        // main keeps its stale value; it is not presented.
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Output decodes: handshake and occupancy come only from the state register.
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
        count     = CNT_W'(state_q);
        dbg_state = state_q;
    end

    // Payload registers: main feeds out_data, skid catches the overflow entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            main_q <= RESET;
            skid_q <= RESET;
        end else if (flush) begin
            main_q <= RESET;
            skid_q <= RESET;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed scenarios with literal expectations,
// then a randomized soak against a two-entry FIFO model.
module tb_pipe_skid_buffer;
    import pipe_skid_buffer_pkg::*;

    localparam int         W     = 8;
    localparam logic [7:0] R_VAL = 8'h5A;

    // ---------------- clock / reset ----------------
    logic         clock = 1'b0;
    logic         reset_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   count;
    state_t       dbg_state;

    always #5 clock = ~clock;

    pipe_skid_buffer #(.WIDTH(W), .RESET(R_VAL)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update at the active edge: a stage of depth two accepts when it
    // holds fewer than two entries and presents when it holds any.
    task automatic model_edge();
        bit m_in_fire;
        bit m_out_fire;
        m_in_fire  = in_valid && (exp_q.size() < 2);
        m_out_fire = out_ready && (exp_q.size() > 0);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (m_out_fire) void'(exp_q.pop_front());
            if (m_in_fire) exp_q.push_back(in_data);
        end
    endtask

    // Compare process: every falling edge, outputs must match the model.
    always @(negedge clock) begin
        chk("model_count", 32'(count), 32'(exp_q.size()));
        chk("model_out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        chk("model_in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
        if (exp_q.size() > 0) chk("model_out_data", 32'(out_data), 32'(exp_q[0]));
    end

    // ---------------- driver ----------------
    // Called just after a falling edge: drive inputs, take one active edge,
    // return just after the next falling edge (compare already done).
    task automatic tick(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clock);
        model_edge();
        @(negedge clock);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) tick(1'b0, '0, 1'b1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #22;
        chk("reset_out_data", 32'(out_data), 32'(R_VAL));
        chk("reset_count", 32'(count), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        #1;

        // Streaming: one transfer per cycle, one cycle latency.
        for (int i = 1; i <= 10; i++) begin
            tick(1'b1, W'(i), 1'b1, 1'b0);
            chk("stream_data", 32'(out_data), 32'(i));
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_in_ready", 32'(in_ready), 32'd1);
        end
        drain();
        chk("stream_drained_valid", 32'(out_valid), 32'd0);

        // Backpressure fill and release.
        tick(1'b1, 8'h0A, 1'b0, 1'b0);
        chk("bp_a_data", 32'(out_data), 32'h0A);
        tick(1'b1, 8'h0B, 1'b0, 1'b0);
        chk("bp_full_count", 32'(count), 32'd2);
        chk("bp_full_in_ready", 32'(in_ready), 32'd0);
        chk("bp_full_data", 32'(out_data), 32'h0A);
        tick(1'b1, 8'h0C, 1'b0, 1'b0);
        chk("bp_held_data", 32'(out_data), 32'h0A);
        chk("bp_held_count", 32'(count), 32'd2);
        tick(1'b1, 8'h0C, 1'b1, 1'b0);
        chk("bp_rel_b", 32'(out_data), 32'h0B);
        chk("bp_rel_in_ready", 32'(in_ready), 32'd1);
        tick(1'b1, 8'h0C, 1'b1, 1'b0);
        chk("bp_rel_c", 32'(out_data), 32'h0C);
        chk("bp_rel_count", 32'(count), 32'd1);
        drain();

        // Simultaneous in/out while BUSY.
        tick(1'b1, 8'h05, 1'b0, 1'b0);
        chk("sim_hold5", 32'(out_data), 32'h05);
        tick(1'b1, 8'h06, 1'b1, 1'b0);
        chk("sim_data6", 32'(out_data), 32'h06);
        chk("sim_count", 32'(count), 32'd1);
        drain();

        // Flush while FULL with a coincident input.
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        tick(1'b1, 8'h22, 1'b0, 1'b0);
        chk("fl_pre_count", 32'(count), 32'd2);
        tick(1'b1, 8'h33, 1'b0, 1'b1);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_out_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);
        chk("fl_out_data", 32'(out_data), 32'(R_VAL));
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            chk("fl_stays_empty", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-cycle while FULL.
        tick(1'b1, 8'h44, 1'b0, 1'b0);
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        chk("ar_pre_count", 32'(count), 32'd2);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("ar_out_valid", 32'(out_valid), 32'd0);
        chk("ar_in_ready", 32'(in_ready), 32'd1);
        chk("ar_count", 32'(count), 32'd0);
        chk("ar_out_data", 32'(out_data), 32'(R_VAL));
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        in_valid = 1'b0;

        // Random soak.
        for (int n = 0; n < 10000; n++) begin
            tick(1'($urandom_range(0, 99) < 70), W'($urandom), 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 99) < 5));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
